// File: rtl/if_gen_pkg.sv
// Shared types and constants for the IF pulse generator.
package if_gen_pkg;

  // Waveform selection latched per PRI.
  typedef enum logic [1:0] {
    MODE_UP    = 2'b00,
    MODE_DOWN  = 2'b01,
    MODE_CW    = 2'b10,
    MODE_BLANK = 2'b11
  } mode_e;

  // Pulse-train sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Cycles from the counter value to the matching sample on out.
  localparam int IF_LATENCY = 2;

endpackage

// File: rtl/if_wave_rom.sv
// Waveform sample ROM: registered address, sample available one cycle later.
// Contents are an odd-step phase ramp, so every address maps to a unique sample.
module if_wave_rom #(
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  data
);

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [31:0]       sample;

  // Next address is simply the requested one.
  always_comb begin
    addr_d = addr;
  end

  // Address register; cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_q <= '0;
    else      addr_q <= addr_d;
  end

  // Table lookup on the registered address.
  always_comb begin
    sample = 32'(addr_q) * 32'd7 + 32'd3;
    data   = sample[WIDTH-1:0];
  end

endmodule

// File: rtl/send_if_pulse_gen.sv
// Radar IF pulse-train generator: PRI sequencing, config shadowing,
// chirp/CW/blank addressing into the waveform ROM, and a 2-cycle output pipe.
module send_if_pulse_gen
  import if_gen_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 12,
  parameter int PRI_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PRI_W-1:0] cfg_pri,
  input  logic [PRI_W-1:0] cfg_pw,
  input  logic [1:0]       cfg_mode,
  output logic [WIDTH-1:0] out,
  output logic             pulse_active,
  output logic             prt_sync,
  output logic [15:0]      pulse_cnt
);

  localparam int ROM_DEPTH = 1 << ADDR_W;

  state_e                state_d, state_q;
  logic [PRI_W-1:0]      cnt_d, cnt_q;
  logic [PRI_W-1:0]      pri_d, pri_q;
  logic [PRI_W-1:0]      pw_d, pw_q;
  mode_e                 mode_d, mode_q;
  logic [IF_LATENCY-1:0] vld_pipe_d, vld_pipe_q;
  logic [IF_LATENCY-1:0] sync_pipe_d, sync_pipe_q;
  logic [WIDTH-1:0]      out_d, out_q;
  logic [15:0]           pulse_cnt_d, pulse_cnt_q;

  logic [PRI_W-1:0]      pri_clamp, pw_clamp;
  logic                  latch_cfg;
  logic                  last_cyc;
  logic                  gate;
  logic                  pri_start;
  logic [ADDR_W-1:0]     rom_addr;
  logic [WIDTH-1:0]      rom_data;

  // Clamp the live config so a latched PRI is >=2 and the pulse fits both
  // the PRI and the ROM.
  always_comb begin
    pri_clamp = (cfg_pri < PRI_W'(2)) ? PRI_W'(2) : cfg_pri;
    pw_clamp  = (cfg_pw < pri_clamp) ? cfg_pw : pri_clamp;
    if (32'(pw_clamp) > 32'(ROM_DEPTH)) pw_clamp = PRI_W'(ROM_DEPTH);
  end

  // Sequencer: next state, PRI counter, and shadow config capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pri_d     = pri_q;
    pw_d      = pw_q;
    mode_d    = mode_q;
    latch_cfg = 1'b0;
    last_cyc  = (cnt_q == pri_q - PRI_W'(1));
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d   = ST_RUN;
          latch_cfg = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_cyc) begin
          cnt_d = '0;
          // enable is only looked at here, so a short dropout mid-PRI is ignored
          if (!enable) state_d = ST_IDLE;
          else         latch_cfg = 1'b1;
        end else begin
          cnt_d = cnt_q + PRI_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (latch_cfg) begin
      pri_d  = pri_clamp;
      pw_d   = pw_clamp;
      mode_d = mode_e'(cfg_mode);
    end
  end

  // Pulse gate and ROM address for the current counter value.
  always_comb begin
    gate      = (state_q == ST_RUN) && (cnt_q < pw_q) && (mode_q != MODE_BLANK);
    pri_start = (state_q == ST_RUN) && (cnt_q == '0);
    rom_addr  = '0;
    if (gate) begin
      case (mode_q)
        MODE_UP:   rom_addr = ADDR_W'(cnt_q);
        // cnt < 2^ADDR_W here, so the complement is 2^ADDR_W-1-cnt
        MODE_DOWN: rom_addr = ~ADDR_W'(cnt_q);
        default:   rom_addr = '0;
      endcase
    end
  end

  if_wave_rom #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (rom_addr),
    .data (rom_data)
  );

  // Output pipe: gate/start bits ride alongside the ROM read; the sample is
  // registered once more so everything lines up two cycles after the count.
  always_comb begin
    vld_pipe_d  = {vld_pipe_q[IF_LATENCY-2:0], gate};
    sync_pipe_d = {sync_pipe_q[IF_LATENCY-2:0], pri_start};
    out_d       = vld_pipe_q[IF_LATENCY-2] ? rom_data : '0;
    pulse_cnt_d = sync_pipe_q[IF_LATENCY-2] ? pulse_cnt_q + 16'd1 : pulse_cnt_q;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pri_q       <= '0;
      pw_q        <= '0;
      mode_q      <= MODE_UP;
      vld_pipe_q  <= '0;
      sync_pipe_q <= '0;
      out_q       <= '0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pri_q       <= pri_d;
      pw_q        <= pw_d;
      mode_q      <= mode_d;
      vld_pipe_q  <= vld_pipe_d;
      sync_pipe_q <= sync_pipe_d;
      out_q       <= out_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign out          = out_q;
  assign pulse_active = vld_pipe_q[IF_LATENCY-1];
  assign prt_sync     = sync_pipe_q[IF_LATENCY-1];
  assign pulse_cnt    = pulse_cnt_q;

endmodule

// File: tb/tb_send_if_pulse_gen.sv
// Directed bench for send_if_pulse_gen. Cycle c = c-th clock period after the
// edge that first samples enable=1 (cycle 0 has cnt=0).
module tb_send_if_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] cfg_pri;
  logic [15:0] cfg_pw;
  logic [1:0]  cfg_mode;
  logic [11:0] out;
  logic        pulse_active;
  logic        prt_sync;
  logic [15:0] pulse_cnt;

  int checks = 0;
  int errors = 0;

  send_if_pulse_gen #(.WIDTH(12), .ADDR_W(12), .PRI_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_pri      (cfg_pri),
    .cfg_pw       (cfg_pw),
    .cfg_mode     (cfg_mode),
    .out          (out),
    .pulse_active (pulse_active),
    .prt_sync     (prt_sync),
    .pulse_cnt    (pulse_cnt)
  );

  always #5 clk = ~clk;

  // ROM contents: sample = 7*addr + 3 modulo 4096.
  function automatic logic [11:0] rom(int a);
    return 12'(a * 7 + 3);
  endfunction

  // Expected outputs for a steady train with effective pri/pw, started at cycle 0.
  function automatic logic exp_pa(int c, int pri, int pw, int mode);
    if (c < 2 || mode == 3) return 1'b0;
    return ((c - 2) % pri) < pw;
  endfunction

  function automatic logic exp_ps(int c, int pri);
    if (c < 2) return 1'b0;
    return ((c - 2) % pri) == 0;
  endfunction

  function automatic logic [11:0] exp_out(int c, int pri, int pw, int mode);
    int k;
    if (!exp_pa(c, pri, pw, mode)) return 12'd0;
    k = (c - 2) % pri;
    case (mode)
      0:       return rom(k);
      1:       return rom(4095 - k);
      default: return rom(0);
    endcase
  endfunction

  task automatic do_reset();
    rst    = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic start(int pri, int pw, int mode);
    cfg_pri  = 16'(pri);
    cfg_pw   = 16'(pw);
    cfg_mode = 2'(mode);
    enable   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0;
    cfg_pri = 16'd100; cfg_pw = 16'd20; cfg_mode = 2'd0;
    @(negedge clk);
    checks++;
    if ({out, pulse_active, prt_sync, pulse_cnt} !== 30'd0) begin
      errors++;
      $display("FAIL reset_hold got out=%0d pa=%b ps=%b pc=%0d want all 0", out, pulse_active, prt_sync, pulse_cnt);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({out, pulse_active, prt_sync, pulse_cnt} !== 30'd0) begin
      errors++;
      $display("FAIL idle_no_enable got out=%0d pa=%b ps=%b pc=%0d want all 0", out, pulse_active, prt_sync, pulse_cnt);
    end
  endtask

  task automatic test_up_chirp();
    do_reset();
    start(100, 20, 0);
    for (int c = 0; c < 250; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({pulse_active, prt_sync, out} !== {exp_pa(c, 100, 20, 0), exp_ps(c, 100), exp_out(c, 100, 20, 0)}) begin
        errors++;
        $display("FAIL up c=%0d got pa=%b ps=%b out=%0d want pa=%b ps=%b out=%0d", c, pulse_active, prt_sync, out,
                 exp_pa(c, 100, 20, 0), exp_ps(c, 100), exp_out(c, 100, 20, 0));
      end
    end
    checks++;
    if (pulse_cnt !== 16'd3) begin errors++; $display("FAIL up_pulse_cnt got %0d want 3", pulse_cnt); end
  endtask

  task automatic test_down_chirp();
    do_reset();
    start(100, 4, 1);
    for (int c = 0; c < 110; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({pulse_active, prt_sync, out} !== {exp_pa(c, 100, 4, 1), exp_ps(c, 100), exp_out(c, 100, 4, 1)}) begin
        errors++;
        $display("FAIL down c=%0d got pa=%b ps=%b out=%0d want pa=%b ps=%b out=%0d", c, pulse_active, prt_sync, out,
                 exp_pa(c, 100, 4, 1), exp_ps(c, 100), exp_out(c, 100, 4, 1));
      end
    end
  endtask

  // CW holds address 0; blank keeps PRI timing with no pulse.
  task automatic test_cw_blank();
    for (int m = 2; m < 4; m++) begin
      do_reset();
      start(10, 3, m);
      for (int c = 0; c < 30; c++) begin
        @(posedge clk); @(negedge clk);
        checks++;
        if ({pulse_active, prt_sync, out} !== {exp_pa(c, 10, 3, m), exp_ps(c, 10), exp_out(c, 10, 3, m)}) begin
          errors++;
          $display("FAIL mode%0d c=%0d got pa=%b ps=%b out=%0d want pa=%b ps=%b out=%0d", m, c, pulse_active, prt_sync,
                   out, exp_pa(c, 10, 3, m), exp_ps(c, 10), exp_out(c, 10, 3, m));
        end
      end
    end
  endtask

  task automatic test_clamp();
    // pw 300 > pri 100: pulse fills the whole PRI
    do_reset();
    start(100, 300, 0);
    for (int c = 0; c < 210; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({pulse_active, prt_sync, out} !== {exp_pa(c, 100, 100, 0), exp_ps(c, 100), exp_out(c, 100, 100, 0)}) begin
        errors++;
        $display("FAIL pw_clamp c=%0d got pa=%b ps=%b out=%0d want pa=%b ps=%b out=%0d", c, pulse_active, prt_sync, out,
                 exp_pa(c, 100, 100, 0), exp_ps(c, 100), exp_out(c, 100, 100, 0));
      end
    end
    // pri 1 becomes 2
    do_reset();
    start(1, 1, 0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({pulse_active, prt_sync, out} !== {exp_pa(c, 2, 1, 0), exp_ps(c, 2), exp_out(c, 2, 1, 0)}) begin
        errors++;
        $display("FAIL pri_clamp c=%0d got pa=%b ps=%b out=%0d want pa=%b ps=%b out=%0d", c, pulse_active, prt_sync, out,
                 exp_pa(c, 2, 1, 0), exp_ps(c, 2), exp_out(c, 2, 1, 0));
      end
    end
    checks++;
    if (pulse_cnt !== 16'd9) begin errors++; $display("FAIL pri_clamp_cnt got %0d want 9", pulse_cnt); end
    // pw 0: timing continues, no pulse
    do_reset();
    start(10, 0, 0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({pulse_active, prt_sync, out} !== {1'b0, exp_ps(c, 10), 12'd0}) begin
        errors++;
        $display("FAIL pw_zero c=%0d got pa=%b ps=%b out=%0d want pa=0 ps=%b out=0", c, pulse_active, prt_sync, out,
                 exp_ps(c, 10));
      end
    end
    checks++;
    if (pulse_cnt !== 16'd4) begin errors++; $display("FAIL pw_zero_cnt got %0d want 4", pulse_cnt); end
  endtask

  task automatic test_cfg_change();
    logic        pa_e, ps_e;
    logic [11:0] out_e;
    do_reset();
    start(100, 20, 0);
    for (int c = 0; c < 211; c++) begin
      @(posedge clk); @(negedge clk);
      if (c < 102) begin
        pa_e = exp_pa(c, 100, 20, 0); ps_e = exp_ps(c, 100); out_e = exp_out(c, 100, 20, 0);
      end else begin
        pa_e = exp_pa(c - 100, 50, 20, 0); ps_e = exp_ps(c - 100, 50); out_e = exp_out(c - 100, 50, 20, 0);
      end
      checks++;
      if ({pulse_active, prt_sync, out} !== {pa_e, ps_e, out_e}) begin
        errors++;
        $display("FAIL cfg_change c=%0d got pa=%b ps=%b out=%0d want pa=%b ps=%b out=%0d", c, pulse_active, prt_sync,
                 out, pa_e, ps_e, out_e);
      end
      if (c == 30) cfg_pri = 16'd50;
    end
    checks++;
    if (pulse_cnt !== 16'd4) begin errors++; $display("FAIL cfg_change_cnt got %0d want 4", pulse_cnt); end
  endtask

  task automatic test_enable_drop();
    logic        pa_e, ps_e;
    logic [11:0] out_e;
    do_reset();
    start(100, 20, 0);
    for (int c = 0; c < 261; c++) begin
      @(posedge clk); @(negedge clk);
      pa_e  = (c < 202) ? exp_pa(c, 100, 20, 0) : 1'b0;
      ps_e  = (c < 202) ? exp_ps(c, 100) : 1'b0;
      out_e = (c < 202) ? exp_out(c, 100, 20, 0) : 12'd0;
      checks++;
      if ({pulse_active, prt_sync, out} !== {pa_e, ps_e, out_e}) begin
        errors++;
        $display("FAIL en_drop c=%0d got pa=%b ps=%b out=%0d want pa=%b ps=%b out=%0d", c, pulse_active, prt_sync, out,
                 pa_e, ps_e, out_e);
      end
      if (c == 110) enable = 1'b0;
    end
    checks++;
    if (pulse_cnt !== 16'd2) begin errors++; $display("FAIL en_drop_cnt got %0d want 2", pulse_cnt); end
  endtask

  // Stopping while the pulse runs to the PRI end: final samples still drain.
  task automatic test_drain();
    logic        pa_e, ps_e;
    logic [11:0] out_e;
    do_reset();
    start(10, 10, 0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); @(negedge clk);
      pa_e  = (c < 12) ? exp_pa(c, 10, 10, 0) : 1'b0;
      ps_e  = (c < 12) ? exp_ps(c, 10) : 1'b0;
      out_e = (c < 12) ? exp_out(c, 10, 10, 0) : 12'd0;
      checks++;
      if ({pulse_active, prt_sync, out} !== {pa_e, ps_e, out_e}) begin
        errors++;
        $display("FAIL drain c=%0d got pa=%b ps=%b out=%0d want pa=%b ps=%b out=%0d", c, pulse_active, prt_sync, out,
                 pa_e, ps_e, out_e);
      end
      if (c == 3) enable = 1'b0;
    end
    checks++;
    if (pulse_cnt !== 16'd1) begin errors++; $display("FAIL drain_cnt got %0d want 1", pulse_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start(100, 20, 0);
    for (int c = 0; c < 210; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({pulse_active, prt_sync, out} !== {exp_pa(c, 100, 20, 0), exp_ps(c, 100), exp_out(c, 100, 20, 0)}) begin
        errors++;
        $display("FAIL en_glitch c=%0d got pa=%b ps=%b out=%0d want pa=%b ps=%b out=%0d", c, pulse_active, prt_sync,
                 out, exp_pa(c, 100, 20, 0), exp_ps(c, 100), exp_out(c, 100, 20, 0));
      end
      if (c == 30) enable = 1'b0;
      if (c == 40) enable = 1'b1;
    end
    checks++;
    if (pulse_cnt !== 16'd3) begin errors++; $display("FAIL en_glitch_cnt got %0d want 3", pulse_cnt); end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    start(100, 20, 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if ({pulse_active, out, pulse_cnt} !== {1'b1, rom(3), 16'd1}) begin
      errors++;
      $display("FAIL pre_reset got pa=%b out=%0d pc=%0d want pa=1 out=%0d pc=1", pulse_active, out, pulse_cnt, rom(3));
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({out, pulse_active, prt_sync, pulse_cnt} !== 30'd0) begin
      errors++;
      $display("FAIL async_reset got out=%0d pa=%b ps=%b pc=%0d want all 0", out, pulse_active, prt_sync, pulse_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 121; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({pulse_active, prt_sync, out} !== {exp_pa(c, 100, 20, 0), exp_ps(c, 100), exp_out(c, 100, 20, 0)}) begin
        errors++;
        $display("FAIL restart c=%0d got pa=%b ps=%b out=%0d want pa=%b ps=%b out=%0d", c, pulse_active, prt_sync, out,
                 exp_pa(c, 100, 20, 0), exp_ps(c, 100), exp_out(c, 100, 20, 0));
      end
    end
    checks++;
    if (pulse_cnt !== 16'd2) begin errors++; $display("FAIL restart_cnt got %0d want 2", pulse_cnt); end
  endtask

  initial begin
    test_reset();
    test_up_chirp();
    test_down_chirp();
    test_cw_blank();
    test_clamp();
    test_cfg_change();
    test_enable_drop();
    test_drain();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/send_if_pulse_gen.md
SEND_IF_PULSE_GEN -- requirements
Module: send_if_pulse_gen

Interface
REQ-001 Parameter WIDTH, default 12: output sample width.
REQ-002 Parameter ADDR_W, default 12: waveform ROM address width (2^ADDR_W samples).
REQ-003 Parameter PRI_W, default 16: width of PRI counter and config ports.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  high = run pulse train; low = stop at end of current PRI.
REQ-007 cfg_pri  input  PRI_W  PRI length in clk cycles.
REQ-008 cfg_pw  input  PRI_W  pulse width in clk cycles.
REQ-009 cfg_mode  input  2  00 LFM up-chirp, 01 LFM down-chirp, 10 CW (ROM address held at 0), 11 blank (no pulse).
REQ-010 out  output  WIDTH  IF sample, 0 outside pulse.
REQ-011 pulse_active  output  1  high while out carries a pulse sample.
REQ-012 prt_sync  output  1  one-cycle strobe marking start of each PRI.
REQ-013 pulse_cnt  output  16  number of PRIs started since reset, wraps at 65535->0.

Function
REQ-014 FSM states IDLE, RUN; IDLE->RUN when enable=1; RUN->IDLE on last PRI cycle (cnt==pri_r-1) when enable=0; otherwise RUN continues.
REQ-015 Config (cfg_pri, cfg_pw, cfg_mode) sampled into shadow regs pri_r/pw_r/mode_r on IDLE->RUN and at every PRI wrap only; mid-PRI changes have no effect.
REQ-016 Clamping at latch: pri_r = max(cfg_pri,2); pw_r = min(cfg_pw, pri_r, 2^ADDR_W).
REQ-017 Counter cnt runs 0..pri_r-1 in RUN, wraps to 0; held 0 in IDLE.
REQ-018 ROM address for cnt<pw_r: up = cnt; down = 2^ADDR_W-1-cnt; CW = 0; blank issues none.
REQ-019 Gate g = RUN and cnt<pw_r and mode_r!=11; pw_r=0 gives no pulse but PRI timing and prt_sync continue.
REQ-020 Fixed latency 2 cycles: out = ROM[addr(cnt=k)] and pulse_active=1 exactly 2 cycles after cycle with cnt=k and g=1; else out=0, pulse_active=0.
REQ-021 prt_sync asserted 2 cycles after each cycle with RUN and cnt==0 (aligned with first sample); pulse_cnt increments in the same cycle prt_sync asserts.
REQ-022 enable toggled low then high within one PRI: train continues uninterrupted, no extra prt_sync.
REQ-023 On RUN->IDLE, the 2-cycle pipeline drains the final samples normally, then out=0.

Reset
REQ-024 rst=0 asynchronously forces FSM=IDLE, cnt=0, shadow regs=0, out=0, pulse_active=0, prt_sync=0, pulse_cnt=0, pipeline cleared, including mid-pulse.
REQ-025 After rst release, first PRI starts the first cycle enable=1 is sampled.

Structure
REQ-026 Mode encodings (MODE_UP, MODE_DOWN, MODE_CW, MODE_BLANK), FSM state type and latency constant (2) live in shared package if_gen_pkg.
REQ-027 One sub-module if_wave_rom (ADDR_W address, WIDTH data, registered address, 1-cycle read); the top adds one output register to reach REQ-020 latency.
REQ-028 No other sub-modules; everything else in send_if_pulse_gen.

Verification
REQ-029 cfg_pri=100, cfg_pw=20, mode=00, enable=1 -> prt_sync every 100 cycles, pulse_active exactly 20 cycles/PRI, out = ROM[0..19] in order, first sample 2 cycles after start.
REQ-030 mode=01, pw=4 -> out = ROM[4095], ROM[4094], ROM[4093], ROM[4092].
REQ-031 cfg_pw=300 with cfg_pri=100 -> pulse_active 100 cycles/PRI; cfg_pri=1 -> PRI of 2 cycles; cfg_pw=0 -> prt_sync continues, out stays 0.
REQ-032 cfg_pri changed 100->50 at cnt=30 -> current PRI still 100 cycles, next PRI 50.
REQ-033 enable dropped at cnt=10 of PRI -> remainder of PRI completes, IDLE afterwards, pulse_cnt stops at final value.
REQ-034 rst asserted at cnt=5 mid-pulse -> out, pulse_active, pulse_cnt zero immediately (no clk edge); restart after release matches REQ-029 timing.
